// File: rtl/rf_port_sequencer.sv
// Dual-read / single-write register-file front end over a single-port sync RAM.
// Optional starvation guard for pending reads: RF_SEQ_STARVE_GUARD_EN.
module rf_port_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs1_data,
  output logic [DATA_W-1:0] rsp_rs2_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WAIT, RESP} state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] rs1_q, rs2_q, src;
  logic              pend_q, in_rd, src_nz, force_rd, wr_acc, rd_issue, stall;

`ifdef RF_SEQ_STARVE_GUARD_EN
  // Counts back-to-back read-phase cycles lost to writes; any other cycle clears it.
  logic [1:0] gcnt_q;
  assign force_rd = (gcnt_q == 2'd3);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     gcnt_q <= '0;
    else if (stall) gcnt_q <= gcnt_q + 2'd1;
    else            gcnt_q <= '0;
  end
`else
  assign force_rd = 1'b0;
`endif

  always_comb begin
    in_rd     = (state == RD1) || (state == RD2);
    src       = (state == RD2) ? rs2_q : rs1_q;
    src_nz    = |src;
    req_ready = (state == IDLE);
    wr_ready  = !(in_rd && src_nz && force_rd);
    wr_acc    = wr_valid && wr_ready;
    // x0 source needs no port cycle, so a write never holds it up
    stall     = in_rd && src_nz && wr_acc;
    rd_issue  = in_rd && src_nz && !wr_acc;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_acc && |wr_addr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = src;
    end
    nxt = state;
    case (state)
      IDLE:    if (req_valid) nxt = RD1;
      RD1:     if (!stall)    nxt = RD2;
      RD2:     if (!stall)    nxt = WAIT;
      WAIT:                   nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pend_q       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else begin
      state     <= nxt;
      pend_q    <= rd_issue;
      rsp_valid <= (nxt == RESP);
      if (state == IDLE && req_valid) begin
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
      end
      // Later assignments win: a snooped write overrides RAM data returning the same cycle.
      if (state == RD1 && !src_nz) rsp_rs1_data <= '0;
      if (state == RD2 && pend_q)  rsp_rs1_data <= mem_rdata;
      if ((state == RD2 || state == WAIT) && wr_acc && |rs1_q && wr_addr == rs1_q)
        rsp_rs1_data <= wr_data;
      if (state == RD2 && !src_nz) rsp_rs2_data <= '0;
      if (state == WAIT && pend_q) rsp_rs2_data <= mem_rdata;
      if (state == WAIT && wr_acc && |rs2_q && wr_addr == rs2_q)
        rsp_rs2_data <= wr_data;
    end
  end

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Bench: transaction-level regfile shadow plus per-cycle output compare, directed and random traffic.
module tb_rf_port_sequencer;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_rs1 = '0, req_rs2 = '0;
  logic          rsp_valid, rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rs1_data, rsp_rs2_data;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  rf_port_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // single-port RAM, 1-cycle read latency
  logic [DW-1:0] ram [16];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: architectural register values, request progress, response snapshot.
  logic [DW-1:0] arch [16];
  logic [DW-1:0] e1, e2;
  logic [AW-1:0] a1, a2;
  int ph = 0;   // 0 idle, 1 need rs1, 2 need rs2, 3 wait, 4 respond
  int sc = 0;   // consecutive read-phase cycles lost to writes
  int nrd = 0, nen = 0;

  always @(negedge clk) begin
    logic [AW-1:0] s;
    logic          ewr, acc, rd, en;
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp1", rsp_rs1_data, 0);
      chk("rst_rsp2", rsp_rs2_data, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_en", mem_en, 0);
      ph = 0;
      sc = 0;
    end else begin
      s   = (ph == 1) ? a1 : a2;
      ewr = 1'b1;
`ifdef RF_SEQ_STARVE_GUARD_EN
      if ((ph == 1 || ph == 2) && s != 0 && sc == 3) ewr = 1'b0;
`endif
      acc = wr_valid && ewr;
      rd  = (ph == 1 || ph == 2) && s != 0 && !acc;
      chk("wr_ready", wr_ready, ewr);
      chk("req_ready", req_ready, ph == 0);
      chk("rsp_valid", rsp_valid, ph == 4);
      if (ph == 4) begin
        chk("rsp1", rsp_rs1_data, e1);
        chk("rsp2", rsp_rs2_data, e2);
      end
      en = (acc && wr_addr != 0) || rd;
      chk("mem_en", mem_en, en);
      if (en && mem_en) begin
        chk("mem_we", mem_we, acc && wr_addr != 0);
        chk("mem_addr", mem_addr, (acc && wr_addr != 0) ? wr_addr : s);
        if (acc && wr_addr != 0) chk("mem_wdata", mem_wdata, wr_data);
      end
      if (mem_en) nen++;
      if (mem_en && !mem_we) nrd++;
      if (acc && wr_addr != 0) arch[wr_addr] = wr_data;
      case (ph)
        0: if (req_valid) begin a1 = req_rs1; a2 = req_rs2; ph = 1; end
        1, 2: if (s != 0 && acc) sc++;
              else begin sc = 0; ph++; end
        3: begin e1 = arch[a1]; e2 = arch[a2]; ph = 4; end
        4: if (rsp_ready) ph = 0;
        default: ph = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  // Issue a request from IDLE; a write (wa,wd) is driven in cycles [ws, ws+wl) counted from
  // acceptance (cycle 0). Returns the cycle rsp_valid appears and the data shown then.
  task automatic rd_req(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input int ws, input int wl, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        output int lat, output logic [DW-1:0] d1, output logic [DW-1:0] d2);
    req_valid = 1'b1; req_rs1 = r1; req_rs2 = r2;
    step();
    req_valid = 1'b0;
    lat = 1;
    wr_addr = wa; wr_data = wd;
    wr_valid = (lat >= ws && lat < ws + wl);
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
      wr_valid = (lat >= ws && lat < ws + wl);
    end
    wr_valid = 1'b0;
    d1 = rsp_rs1_data;
    d2 = rsp_rs2_data;
  endtask

  initial begin
    int lat, n0, e0;
    logic [DW-1:0] d1, d2;
    for (int i = 0; i < 16; i++) begin
      ram[i]  = $urandom;
      arch[i] = ram[i];
    end
    arch[0] = '0;
    #23 rst_n = 1'b1;
    step();

    // basic read
    wr1(4'd3, 32'h11);
    wr1(4'd5, 32'h22);
    n0 = nrd;
    rd_req(4'd3, 4'd5, 0, 0, 4'd0, 32'h0, lat, d1, d2);
    chk("basic_lat", lat, 4);
    chk("basic_rs1", d1, 32'h11);
    chk("basic_rs2", d2, 32'h22);
    chk("basic_nrd", nrd - n0, 2);
    step();

    // x0 handling
    e0 = nen;
    rd_req(4'd0, 4'd0, 0, 0, 4'd0, 32'h0, lat, d1, d2);
    chk("x0_lat", lat, 4);
    chk("x0_rs1", d1, 0);
    chk("x0_rs2", d2, 0);
    chk("x0_no_mem", nen - e0, 0);
    step();
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF;
    #1;
    chk("x0w_ready", wr_ready, 1);
    chk("x0w_mem_en", mem_en, 0);
    step();
    wr_valid = 1'b0;
    rd_req(4'd0, 4'd3, 0, 0, 4'd0, 32'h0, lat, d1, d2);
    chk("x0r_rs1", d1, 0);
    chk("x0r_rs2", d2, 32'h11);
    step();

    // write priority in RD1
    rd_req(4'd3, 4'd5, 1, 2, 4'd7, 32'hA5, lat, d1, d2);
    chk("wprio_lat", lat, 6);
    chk("wprio_rs1", d1, 32'h11);
    chk("wprio_ram7", ram[7], 32'hA5);
    step();

    // snoop: write lands in the RD2 cycle where rs1 data returns
    wr1(4'd4, 32'h1);
    rd_req(4'd4, 4'd4, 2, 1, 4'd4, 32'h99, lat, d1, d2);
    chk("snoop_lat", lat, 5);
    chk("snoop_rs1", d1, 32'h99);
    chk("snoop_rs2", d2, 32'h99);
    step();

    // backpressure with a write to rs1 during RESP
    rsp_ready = 1'b0;
    rd_req(4'd3, 4'd5, 0, 0, 4'd0, 32'h0, lat, d1, d2);
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h55;
    for (int i = 0; i < 5; i++) begin
      step();
      wr_valid = 1'b0;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rs1", rsp_rs1_data, 32'h11);
      chk("bp_rs2", rsp_rs2_data, 32'h22);
    end
    chk("bp_ram3", ram[3], 32'h55);
    rsp_ready = 1'b1;
    step();

    // reset mid-RD2
    req_valid = 1'b1; req_rs1 = 4'd5; req_rs2 = 4'd3;
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", rsp_valid, 0);
    chk("mrst_ready", req_ready, 1);
    chk("mrst_rs1", rsp_rs1_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_post_ready", req_ready, 1);

    // continuous write pressure from RD1
    req_valid = 1'b1; req_rs1 = 4'd3; req_rs2 = 4'd5;
    step();
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 32'hC0DE;
    n0 = nrd;
`ifdef RF_SEQ_STARVE_GUARD_EN
    for (int i = 0; i < 3; i++) begin
      chk("guard_wr_ready_early", wr_ready, 1);
      step();
    end
    chk("guard_wr_ready_4th", wr_ready, 0);
    chk("guard_rd_en", mem_en && !mem_we, 1);
    chk("guard_rd_addr", mem_addr, 4'd3);
    step();
    wr_valid = 1'b0;
`else
    for (int i = 0; i < 12; i++) step();
    chk("starve_no_read", nrd - n0, 0);
    wr_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    chk("starve_lat", lat, 3);
`endif
    while (!rsp_valid) step();
    chk("starve_rs1", rsp_rs1_data, 32'h55);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_rs1   = $urandom_range(0, 15);
      req_rs2   = ($urandom_range(0, 3) == 0) ? req_rs1 : 4'($urandom_range(0, 15));
      wr_valid  = ($urandom_range(0, 9) < 4);
      wr_addr   = $urandom_range(0, 15);
      wr_data   = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 1'b0; wr_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("drain_idle", req_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
